// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_sb register file slice: address width
// derivation, default word/address types and the packed-port slice helper.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_NUM_REGS = 8;

  // Address width needed to index num_regs registers (never below 1 bit).
  function automatic int unsigned addr_width(input int unsigned num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

  localparam int unsigned DEF_ADDR_W = addr_width(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  // Low bit of port 'port' inside a packed multi-port bus of 'width'-bit fields.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of regfile_sb: stored value with same-cycle
// write bypass, load writeback (wr1) taking priority over the ALU (wr0).
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic [DATA_W-1:0] data
);

  // Bypass mux: wr1 beats wr0, either beats the stored value.
  always_comb begin
    data = stored;
    if (wr1_en && (wr1_addr == addr)) begin
      data = wr1_data;
    end else if (wr0_en && (wr0_addr == addr)) begin
      data = wr0_data;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with two write ports, write-to-read bypass,
// per-register busy scoreboard and sticky wr0 hazard flag.
// Optional feature macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = DEF_DATA_W,
  parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter  int unsigned NUM_READ = 2,
  localparam int unsigned ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
  output logic [NUM_READ*DATA_W-1:0] rd_data,
  output logic [NUM_READ-1:0]        rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic                       hazard,
  input  logic                       hazard_clr
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  logic wr0_ok;
  logic wr1_ok;
  logic issue_ok;

  // Effective enables. Masking with RESET keeps the bypass from showing write
  // data while reset holds the storage at zero; the zero-register option drops
  // every write/issue to address 0, which also zeroes its bypass path.
  always_comb begin
    wr0_ok   = wr0_en   & ~RESET;
    wr1_ok   = wr1_en   & ~RESET;
    issue_ok = issue_en & ~RESET;
`ifdef REGFILE_ZERO_REG_EN
    if (wr0_addr   == '0) wr0_ok   = 1'b0;
    if (wr1_addr   == '0) wr1_ok   = 1'b0;
    if (issue_addr == '0) issue_ok = 1'b0;
`endif
  end

  // Register storage; wr1 is assigned last so it wins a same-address collision.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
    end
  end

  // Busy scoreboard: wr1 clears, issue sets and wins a same-address collision.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busy <= '0;
    end else begin
      if (wr1_ok)   busy[wr1_addr]   <= 1'b0;
      if (issue_ok) busy[issue_addr] <= 1'b1;
    end
  end

  // Sticky hazard: a wr0 hitting a busy register sets it; set beats clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hazard <= 1'b0;
    end else if (wr0_ok && busy[wr0_addr]) begin
      hazard <= 1'b1;
    end else if (hazard_clr) begin
      hazard <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr       = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];
    assign rd_busy[k] = busy[addr];

    regfile_rd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_rd_port (
      .addr    (addr),
      .stored  (regs[addr]),
      .wr0_en  (wr0_ok),
      .wr0_addr(wr0_addr),
      .wr0_data(wr0_data),
      .wr1_en  (wr1_ok),
      .wr1_addr(wr1_addr),
      .wr1_data(wr1_data),
      .data    (rd_data[slice_lo(k, DATA_W) +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters, 2 read ports).
module tb_regfile_sb;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;
  localparam int NP = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0] rd_busy;
  logic          wr0_en, wr1_en, issue_en, hazard_clr;
  logic [AW-1:0] wr0_addr, wr1_addr, issue_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic          hazard;

  int checks = 0;
  int failures = 0;

  // Reference state kept by the bench.
  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];
  logic          m_hazard;

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_READ(NP)) dut (
    .CLK(CLK), .RESET(RESET),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .hazard(hazard), .hazard_clr(hazard_clr)
  );

  always #5 CLK = ~CLK;

  function automatic bit zero_reg(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return a == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] port_data(input int k);
    logic [NP*DW-1:0] v;
    v = rd_data;
    return v[k*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_hazard = 1'b0;
  endtask

  // Expected read value for an address given the current inputs.
  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (RESET || zero_reg(a)) return '0;
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
    return m_regs[a];
  endfunction

  // Per-cycle comparison of every output against the reference state.
  task automatic compare_model();
    for (int k = 0; k < NP; k++) begin
      logic [AW-1:0] a;
      a = rd_addr[k*AW +: AW];
      chk($sformatf("model_rd_data[%0d]", k), 32'(port_data(k)), 32'(exp_read(a)));
      chk($sformatf("model_rd_busy[%0d]", k), 32'(rd_busy[k]), 32'(m_busy[a]));
    end
    chk("model_hazard", 32'(hazard), 32'(m_hazard));
  endtask

  // Rising edge: apply the write/issue/hazard rules to the reference state.
  task automatic commit();
    bit old_busy;
    @(posedge CLK);
    if (RESET) begin
      model_reset();
    end else begin
      old_busy = m_busy[wr0_addr];
      if (wr0_en && !zero_reg(wr0_addr) && old_busy) m_hazard = 1'b1;
      else if (hazard_clr) m_hazard = 1'b0;
      if (wr0_en && !zero_reg(wr0_addr)) m_regs[wr0_addr] = wr0_data;
      if (wr1_en && !zero_reg(wr1_addr)) m_regs[wr1_addr] = wr1_data;
      if (wr1_en && !zero_reg(wr1_addr)) m_busy[wr1_addr] = 1'b0;
      if (issue_en && !zero_reg(issue_addr)) m_busy[issue_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic cycle();
    @(negedge CLK);
    compare_model();
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; issue_en = 0; hazard_clr = 0;
    wr0_addr = '0; wr1_addr = '0; issue_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    RESET = 1'b1;
    idle();
    set_rd(0, 0);
    model_reset();
    // Reset state on every address, both ports.
    for (int a = 0; a < NR; a++) begin
      set_rd(AW'(a), AW'(NR - 1 - a));
      #1;
      chk("reset_rd0", 32'(port_data(0)), 32'h0);
      chk("reset_rd1", 32'(port_data(1)), 32'h0);
      chk("reset_busy", 32'(rd_busy), 32'h0);
    end
    chk("reset_hazard", 32'(hazard), 32'h0);
    @(negedge CLK);
    compare_model();
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // wr0 bypass then stored.
    wr0_en = 1; wr0_addr = 2; wr0_data = 16'h00AA; set_rd(2, 1);
    cycle();
    chk("wr0_bypass", 32'(port_data(0)), 32'h00AA);
    commit();
    idle(); set_rd(2, 2);
    cycle();
    chk("wr0_stored", 32'(port_data(0)), 32'h00AA);
    commit();

    // wr0/wr1 collision: wr1 wins.
    wr0_en = 1; wr0_addr = 5; wr0_data = 16'h1111;
    wr1_en = 1; wr1_addr = 5; wr1_data = 16'h2222; set_rd(5, 5);
    cycle();
    chk("collide_bypass0", 32'(port_data(0)), 32'h2222);
    chk("collide_bypass1", 32'(port_data(1)), 32'h2222);
    commit();
    idle(); set_rd(5, 2);
    cycle();
    chk("collide_stored", 32'(port_data(0)), 32'h2222);
    commit();

    // Scoreboard: issue, wr1 clear, issue+wr1 same cycle.
    issue_en = 1; issue_addr = 4; set_rd(4, 4);
    cycle();
    chk("busy_not_bypassed", 32'(rd_busy[0]), 32'h0);
    commit();
    idle();
    cycle();
    chk("busy_after_issue", 32'(rd_busy[0]), 32'h1);
    commit();
    wr1_en = 1; wr1_addr = 4; wr1_data = 16'h0F0F;
    cycle();
    chk("busy_before_wr1_edge", 32'(rd_busy[1]), 32'h1);
    commit();
    idle();
    cycle();
    chk("busy_cleared", 32'(rd_busy[1]), 32'h0);
    chk("wr1_stored", 32'(port_data(1)), 32'h0F0F);
    commit();
    issue_en = 1; issue_addr = 4; wr1_en = 1; wr1_addr = 4; wr1_data = 16'h5555;
    cycle();
    commit();
    idle();
    cycle();
    chk("issue_beats_wr1", 32'(rd_busy[0]), 32'h1);
    chk("issue_wr1_data", 32'(port_data(0)), 32'h5555);
    commit();

    // Hazard: set, hold, clear, set beats clear.
    issue_en = 1; issue_addr = 6; set_rd(6, 0);
    cycle(); commit();
    idle(); wr0_en = 1; wr0_addr = 6; wr0_data = 16'h0001;
    cycle();
    chk("hazard_pre_edge", 32'(hazard), 32'h0);
    commit();
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hazard_held", 32'(hazard), 32'h1);
      commit();
    end
    cycle();
    chk("hazard_write_data", 32'(port_data(0)), 32'h0001);
    commit();
    hazard_clr = 1;
    cycle(); commit();
    idle();
    cycle();
    chk("hazard_cleared", 32'(hazard), 32'h0);
    commit();
    hazard_clr = 1; wr0_en = 1; wr0_addr = 6; wr0_data = 16'h0002;
    cycle(); commit();
    idle();
    cycle();
    chk("hazard_set_wins", 32'(hazard), 32'h1);
    commit();
    hazard_clr = 1;
    cycle(); commit();
    idle();

    // Register 0 behaviour.
    wr0_en = 1; wr0_addr = 0; wr0_data = 16'hFFFF; issue_en = 1; issue_addr = 0; set_rd(0, 1);
    cycle(); commit();
    idle();
    cycle();
`ifdef REGFILE_ZERO_REG_EN
    chk("r0_data", 32'(port_data(0)), 32'h0);
    chk("r0_busy", 32'(rd_busy[0]), 32'h0);
`else
    chk("r0_data", 32'(port_data(0)), 32'hFFFF);
    chk("r0_busy", 32'(rd_busy[0]), 32'h1);
`endif
    chk("r0_hazard", 32'(hazard), 32'h0);
    commit();

    // Asynchronous reset mid-cycle discards state and pending writes.
    wr0_en = 1; wr0_addr = 3; wr0_data = 16'h1234; set_rd(3, 4);
    cycle(); commit();
    wr0_en = 1; wr0_addr = 3; wr0_data = 16'hBEEF; issue_en = 1; issue_addr = 3;
    #1;
    chk("r3_bypass_before_reset", 32'(port_data(0)), 32'hBEEF);
    RESET = 1'b1;
    model_reset();
    #1;
    chk("async_reset_r3", 32'(port_data(0)), 32'h0);
    chk("async_reset_busy", 32'(rd_busy), 32'h0);
    chk("async_reset_hazard", 32'(hazard), 32'h0);
    cycle();
    idle();
    RESET = 1'b0;
    commit();
    cycle();
    chk("after_reset_r3", 32'(port_data(0)), 32'h0);
    commit();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
